forward_merge_arbiter: RTL and testbench
========================================

// Module: forward_merge_arbiter
// PURPOSE
//  Round-robin merge of NUM_INPUTS packet FIFOs (e.g. routing buffer, token controller, local spike queue)
//  onto one router output direction. Pops at most one packet per cycle into an internal FWFT output buffer.
//  The output buffer is read by the next hop's forwarding stage through the usual empty/ren handshake.
//  Sits between the per-core packet sources and the east/west/north/south forward stages of the router.
// PARAMETERS
//  PACKET_WIDTH  30  width of one routed packet (dx, dy, axon, tick fields)
//  NUM_INPUTS    3   number of requesting source FIFOs (>=2)
//  BUFFER_DEPTH  4   output buffer entries (power of two, >=2)
// PORTS
//  clk           in   1                          system clock, all logic on rising edge
//  rst           in   1                          synchronous, active-high reset
//  din           in   NUM_INPUTS*PACKET_WIDTH    packed source heads; input i = din[i*PACKET_WIDTH +: PACKET_WIDTH]
//  empty_in      in   NUM_INPUTS                 source i FIFO empty (head valid when 0)
//  ren_out       out  NUM_INPUTS                 one-hot pop strobe to source i (combinational)
//  ren_in        in   1                          downstream pop of output buffer head
//  dout          out  PACKET_WIDTH               output buffer head (FWFT)
//  buffer_empty  out  1                          output buffer empty
//  buffer_full   out  1                          output buffer holds BUFFER_DEPTH packets
//  grant_idx     out  clog2(NUM_INPUTS)          index of last granted input (debug/perf)
// BEHAVIOUR
//  Reset: rr_ptr=0, count=0, rd/wr ptr=0, grant_idx=0, buffer_empty=1, buffer_full=0, ren_out=0, dout=0.
//  Arbiter states: IDLE (no request or buffer full) / GRANT (a pop this cycle); state is implied by req & ~full.
//  req[i] = ~empty_in[i]. If any req and ~buffer_full: grant = first req at index >= rr_ptr, wrapping to 0.
//  ren_out = onehot(grant) combinationally in the same cycle; din slice of grant written to buffer at edge.
//  After a grant: rr_ptr <= (grant+1) mod NUM_INPUTS; grant_idx <= grant. No grant: rr_ptr, grant_idx hold.
//  Full blocks grant even if ren_in is high that cycle (no write-through when full); ren_out all 0.
//  Read: ren_in & ~buffer_empty advances rd ptr; ren_in while empty is ignored (no underflow, count stays 0).
//  Simultaneous write+read (not full, not empty): count unchanged, both pointers advance.
//  Write into empty buffer: dout/buffer_empty update next cycle (1-cycle source-to-dout latency).
//  Pointers wrap modulo BUFFER_DEPTH; count range 0..BUFFER_DEPTH; buffer_full = (count==BUFFER_DEPTH).
//  dout = mem[rd_ptr] registered-FWFT; value when empty is don't-care but must not be X after reset (0).
//  Fairness: with all inputs continuously requesting and buffer never full, each input granted once
//  every NUM_INPUTS cycles; max wait for any requester = NUM_INPUTS-1 grants.
//  Packet contents pass unmodified; no field rewriting (dx/dy adjust stays in forward stages).
//  Reset mid-operation: buffer contents discarded, pending grant in reset cycle suppressed (ren_out=0 while rst).
// TESTING
//  1 Reset: rst=1 2 cycles with all inputs non-empty -> ren_out=0, buffer_empty=1, count=0 throughout.
//  2 Single source: input1 holds 0x0000_0AB, others empty, ren_in=0 -> ren_out=3'b010 at cycle 0,
//    dout=0x0AB, buffer_empty=0 at cycle 1, grant_idx=1.
//  3 Round robin: all 3 inputs non-empty, ren_in=1 every cycle -> grant sequence 0,1,2,0,1,2; buffer count stays <=1.
//  4 Full: all inputs non-empty, ren_in=0 -> 4 grants then buffer_full=1, ren_out=0; one ren_in pulse ->
//    full drops, next cycle exactly one grant to rr_ptr (input 1), full reasserts.
//  5 Underflow/wrap: write 6 packets 0x01..0x06 with interleaved reads -> dout order 0x01..0x06, no read while empty.
//  6 Mid-op reset: buffer holding 3 packets, assert rst 1 cycle -> buffer_empty=1, next grant starts at input 0.

Source files
------------

// File: rtl/forward_merge_arbiter.sv
// Round-robin merge of NUM_INPUTS packet FIFO heads into a small FWFT output buffer.
// One source pop per cycle; the buffer head is presented registered on dout.
module forward_merge_arbiter #(
    parameter int unsigned PACKET_WIDTH = 30,
    parameter int unsigned NUM_INPUTS   = 3,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPUTS*PACKET_WIDTH-1:0]   din,
    input  logic [NUM_INPUTS-1:0]                empty_in,
    output logic [NUM_INPUTS-1:0]                ren_out,
    input  logic                                 ren_in,
    output logic [PACKET_WIDTH-1:0]              dout,
    output logic                                 buffer_empty,
    output logic                                 buffer_full,
    output logic [$clog2(NUM_INPUTS)-1:0]        grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PACKET_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [PACKET_WIDTH-1:0] r_dout;
    logic                    r_empty;
    logic                    r_full;

    logic [NUM_INPUTS-1:0]   w_req;
    logic [2*NUM_INPUTS-1:0] w_rot;
    logic [IDX_W-1:0]        w_off;
    logic [IDX_W:0]          w_sum;
    logic                    w_grant_valid;
    logic [IDX_W-1:0]        w_grant;
    logic                    w_wr;
    logic                    w_rd;
    logic [PACKET_WIDTH-1:0] w_din_sel;
    logic [PTR_W-1:0]        w_rd_ptr_next;
    logic [CNT_W-1:0]        w_count_next;

    assign w_req = ~empty_in;

    // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
    always_comb begin
        w_rot         = {w_req, w_req} >> r_rr_ptr;
        w_off         = '0;
        w_grant_valid = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off         = IDX_W'(k);
                w_grant_valid = 1'b1;
            end
        end
        w_sum = (IDX_W+1)'(r_rr_ptr) + (IDX_W+1)'(w_off);
        if (w_sum >= (IDX_W+1)'(NUM_INPUTS)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_INPUTS);
        end
        w_grant = w_sum[IDX_W-1:0];
    end

    // Full blocks the pop outright, and reset suppresses any pending grant.
    assign w_wr = w_grant_valid & ~r_full & ~rst;
    assign w_rd = ren_in & ~r_empty;

    always_comb begin
        w_din_sel = '0;
        ren_out   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_din_sel  = din[i*PACKET_WIDTH +: PACKET_WIDTH];
                ren_out[i] = w_wr;
            end
        end
    end

    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_rd);
    assign w_count_next  = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_dout      <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_din_sel;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_grant_idx     <= w_grant;
                r_rr_ptr        <= (w_grant == IDX_W'(NUM_INPUTS - 1)) ? '0 : w_grant + IDX_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            r_full   <= (w_count_next == CNT_W'(BUFFER_DEPTH));
            // Bypass the incoming packet when it lands in the slot that becomes the head.
            if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
                r_dout <= w_din_sel;
            end else begin
                r_dout <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign dout         = r_dout;
    assign buffer_empty = r_empty;
    assign buffer_full  = r_full;
    assign grant_idx    = r_grant_idx;

endmodule

// File: tb/tb_forward_merge_arbiter.sv
// Bench for forward_merge_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the merge buffer.
module tb_forward_merge_arbiter;

    localparam int unsigned W = 30;
    localparam int unsigned N = 3;
    localparam int unsigned D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] din;
    logic [N-1:0]   empty_in;
    logic [N-1:0]   ren_out;
    logic           ren_in;
    logic [W-1:0]   dout;
    logic           buffer_empty;
    logic           buffer_full;
    logic [1:0]     grant_idx;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_q[$];
    int           m_rr   = 0;
    int           m_gidx = 0;
    int           m_grant;

    forward_merge_arbiter #(.PACKET_WIDTH(W), .NUM_INPUTS(N), .BUFFER_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .empty_in     (empty_in),
        .ren_out      (ren_out),
        .ren_in       (ren_in),
        .dout         (dout),
        .buffer_empty (buffer_empty),
        .buffer_full  (buffer_full),
        .grant_idx    (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first non-empty source at or after rr, wrapping.
    function automatic int pick(input logic [N-1:0] e, input int rr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (!e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_src(input int i, input logic [W-1:0] v);
        din[i*W +: W] = v;
    endtask

    // Check outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic [N-1:0] exp_ren;
        @(negedge clk);
        m_grant = (rst || m_q.size() == D) ? -1 : pick(empty_in, m_rr);
        exp_ren = '0;
        if (m_grant >= 0) exp_ren[m_grant] = 1'b1;
        chk("ren_out", 32'(ren_out), 32'(exp_ren));
        chk("buffer_empty", 32'(buffer_empty), 32'(m_q.size() == 0));
        chk("buffer_full", 32'(buffer_full), 32'(m_q.size() == D));
        chk("grant_idx", 32'(grant_idx), 32'(m_gidx));
        if (m_q.size() > 0) chk("dout", 32'(dout), 32'(m_q[0]));
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_rr   = 0;
            m_gidx = 0;
        end else begin
            if (ren_in && m_q.size() > 0) void'(m_q.pop_front());
            if (m_grant >= 0) begin
                m_q.push_back(din[m_grant*W +: W]);
                m_rr   = (m_grant + 1) % N;
                m_gidx = m_grant;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int val;
        rst      = 1'b1;
        empty_in = '0;
        ren_in   = 1'b0;
        din      = '0;
        for (int i = 0; i < N; i++) set_src(i, W'(32'h100 + i));
        @(posedge clk);
        #1;

        // Reset held with every source requesting: no pops, buffer empty.
        do_reset(2);
        chk("reset_dout_zero", 32'(dout), 32'h0);

        // Single source on input 1.
        empty_in = 3'b101;
        set_src(1, W'(32'h0AB));
        cycle();
        empty_in = 3'b111;
        cycle();
        chk("single_dout", 32'(dout), 32'h0AB);
        chk("single_gidx", 32'(grant_idx), 32'd1);
        ren_in = 1'b1;
        cycle();
        cycle();

        // Round robin with continuous drain.
        do_reset(1);
        empty_in = 3'b000;
        ren_in   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_src(i, W'(32'h1000 * (i + 1) + c));
            cycle();
        end

        // Fill to full, single read pulse, refill by one.
        do_reset(1);
        ren_in = 1'b0;
        repeat (6) cycle();
        chk("full_asserted", 32'(buffer_full), 32'd1);
        ren_in = 1'b1;
        cycle();
        ren_in = 1'b0;
        cycle();
        chk("refill_gidx", 32'(grant_idx), 32'd1);
        repeat (2) cycle();

        // Ordered stream 0x01..0x06 from input 0 with interleaved reads, read-while-empty first.
        do_reset(1);
        val = 1;
        for (int c = 0; c < 24; c++) begin
            empty_in = (val <= 6) ? 3'b110 : 3'b111;
            set_src(0, W'(val));
            ren_in = (c % 2 == 0);
            cycle();
            if (m_grant == 0) val++;
        end
        chk("stream_drained", 32'(buffer_empty), 32'd1);

        // Mid-operation reset: 3 packets buffered, then reset, then grant restarts at input 0.
        do_reset(1);
        empty_in = 3'b101;
        ren_in   = 1'b0;
        repeat (3) cycle();
        empty_in = 3'b000;
        do_reset(1);
        chk("midrst_empty", 32'(buffer_empty), 32'd1);
        cycle();
        chk("midrst_gidx", 32'(grant_idx), 32'd0);

        // Random traffic with varying read pressure and occasional resets.
        for (int c = 0; c < 600; c++) begin
            empty_in = N'($urandom);
            for (int i = 0; i < N; i++) set_src(i, W'($urandom));
            ren_in = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
